md_seq_ctrl: RTL
================

// Module: md_seq_ctrl
// PURPOSE
//  Sequencer in front of the shared iterative mul/div core. Accepts one RV64M op at a time and
//  resolves div-by-zero/overflow locally. Otherwise it issues unsigned magnitudes to the core,
//  waits for done, applies sign fixup, W-extension and result select, then holds the response
//  until the consumer accepts it.
// PARAMETERS
//  XLEN        64   operand/result width
//  TIMEOUT_CYC 80   max cycles in WAIT before abort+error
// PORTS
//  clk_i          in   1       clock; single clock domain
//  rst_ni         in   1       asynchronous, active-low reset
//  req_valid_i    in   1       request valid
//  req_ready_o    out  1       request ready (high only in IDLE)
//  md_op_i        in   4       [3]=W, [2]=1 mul/0 div; div [1:0]: DIV,DIVU,REM,REMU; mul: MUL,MULH,MULHSU,MULHU
//  X_i, Y_i       in   XLEN    operands
//  core_start_o   out  1       one-cycle start pulse to core
//  core_mul_o     out  1       1=multiply, 0=divide (valid with start)
//  core_X_o/Y_o   out  XLEN    unsigned magnitudes to core
//  core_done_i    in   1       core finished (single-cycle pulse)
//  core_res_i     in   2*XLEN  mul: unsigned product; div: {rem,quot}
//  core_abort_o   out  1       one-cycle abort pulse to core
//  flush_i        in   1       kill in-flight op
//  res_valid_o    out  1       result valid, held until res_ready_i
//  res_ready_i    in   1       consumer accepts result
//  res_o          out  XLEN    result
//  exc_o          out  1       result came from div exception path
//  err_o          out  1       result came from timeout (res_o=0)
// BEHAVIOUR
//  Reset: state IDLE; req_ready_o=1; all other outputs 0; cache (if built) invalid.
//  FSM IDLE->(ISSUE|RESP), ISSUE->WAIT, WAIT->(FIX|RESP), FIX->RESP, RESP->IDLE on res_ready_i.
//  IDLE: on req_valid_i, latch op/X/Y. Div exception -> RESP next cycle (res_valid 1 cycle after accept).
//  Exceptions (div only): Y=0 (W: Y[31:0]=0): DIV*/DIVU* -> all ones; REM*/REMU* -> X (W: sext X[31:0]).
//   Signed overflow X=min,Y=-1: DIV -> 0x8000..0, DIVW -> 0xFFFFFFFF80000000, REM/REMW -> 0. exc_o=1.
//  ISSUE: core_start_o=1 for one cycle. W ops first reduce operands to 32 bits, sign- or zero-extended
//   by signedness. Signed negative operands are 2's-complemented; MULHSU treats Y as unsigned.
//  WAIT: cycle counter runs. On core_done_i, capture core_res_i -> FIX. At TIMEOUT_CYC cycles
//   without done: core_abort_o pulse, res_o=0, err_o=1 -> RESP.
//  FIX: quotient negated if sign(X)!=sign(Y) (signed div); remainder takes sign of X.
//   MUL uses low XLEN of the signed product; MULH/MULHSU/MULHU use the upper XLEN. A product is negated
//   (full 2*XLEN negate) when its operand signs differ. W results are sext of bit 31.
//  RESP: res_valid_o/res_o/exc_o/err_o stable until res_ready_i. req_ready_o=0 outside IDLE.
//  flush_i (any state): next state IDLE, res_valid_o drops next cycle, core_abort_o pulses if in
//   ISSUE/WAIT. A later core_done_i in IDLE is ignored. Flush beats done/ready/timeout in the same cycle.
// CONFIGURATION
//  MD_RESULT_CACHE_EN defined: keep the last core div result {rem,quot} with X, Y, W and signedness.
//   A div request with identical X/Y/W/signedness (e.g. REM then DIV) skips ISSUE/WAIT:
//   IDLE->FIX, no core_start_o. Cache is invalidated by reset, flush, timeout and any new core div.
//  Not defined: every non-exception request issues to the core; no cache storage.
// TESTING
//  DIV X=-7,Y=2; core returns q=3,r=1 -> core_X_o=7, core_Y_o=2; res_o=0xFFFF_FFFF_FFFF_FFFD, exc_o=0.
//  DIVU Y=0 -> res_valid 1 cycle after accept, res_o=all ones, exc_o=1, core_start_o never asserted.
//  DIVW X=0x80000000,Y=0xFFFFFFFF -> res_o=0xFFFFFFFF80000000, exc_o=1; REMW same operands -> 0.
//  MULHSU X=-1,Y=2 -> core gets 1,2; res_o=all ones. MULH X=-1,Y=-1 -> res_o=0.
//  flush_i in WAIT -> core_abort_o pulse, IDLE; subsequent core_done_i yields no res_valid.
//  No core_done_i -> after 80 cycles err_o=1, res_o=0. With cache: REM then DIV same operands -> 1 start.

Source files
------------

// File: rtl/md_seq_ctrl.sv
// md_seq_ctrl: RV64M sequencer in front of the shared iterative mul/div core (optional MD_RESULT_CACHE_EN).
// Latency: div exceptions respond 1 cycle after accept; core ops take issue + core time + fixup + 1.
// Backpressure: one op in flight; req_ready_o only in IDLE, result held until res_ready_i.
module md_seq_ctrl #(
    parameter int XLEN        = 64,
    parameter int TIMEOUT_CYC = 80
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [3:0]        md_op_i,
    input  logic [XLEN-1:0]   X_i,
    input  logic [XLEN-1:0]   Y_i,
    output logic              core_start_o,
    output logic              core_mul_o,
    output logic [XLEN-1:0]   core_X_o,
    output logic [XLEN-1:0]   core_Y_o,
    input  logic              core_done_i,
    input  logic [2*XLEN-1:0] core_res_i,
    output logic              core_abort_o,
    input  logic              flush_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [XLEN-1:0]   res_o,
    output logic              exc_o,
    output logic              err_o
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_FIX,
        S_RESP
    } state_t;

    state_t state_q, state_d;

    logic            in_w, in_mul, in_xsgn, in_ysgn;
    logic [1:0]      in_sub;
    logic [XLEN-1:0] in_x32s, in_xe, in_ye, in_min, in_xmag, in_ymag, exc_res;
    logic            in_xneg, in_yneg, div_zero, div_ovf, in_exc;
    logic            accept, timeout, cache_hit;
    logic [2*XLEN-1:0] cache_res;

    logic [3:0]        op_q;
    logic [XLEN-1:0]   mag_x_q, mag_y_q, res_q;
    logic              neg_x_q, neg_y_q, exc_q, err_q;
    logic [2*XLEN-1:0] res_full_q;
    logic [CW-1:0]     cnt_q;

    logic [XLEN-1:0]   quot, rem, sel, fix_res;
    logic [2*XLEN-1:0] prod;

    // Request decode: operand extension, magnitudes and div exceptions.
    always_comb begin
        in_w    = md_op_i[3];
        in_mul  = md_op_i[2];
        in_sub  = md_op_i[1:0];
        in_xsgn = in_mul ? (in_sub != 2'b11) : ~in_sub[0];
        in_ysgn = in_mul ? ~in_sub[1] : ~in_sub[0];
        in_x32s = {{(XLEN-32){X_i[31]}}, X_i[31:0]};
        if (in_w) begin
            in_xe  = in_xsgn ? in_x32s : {{(XLEN-32){1'b0}}, X_i[31:0]};
            in_ye  = in_ysgn ? {{(XLEN-32){Y_i[31]}}, Y_i[31:0]}
                             : {{(XLEN-32){1'b0}}, Y_i[31:0]};
            in_min = {{(XLEN-31){1'b1}}, 31'b0};
        end else begin
            in_xe  = X_i;
            in_ye  = Y_i;
            in_min = {1'b1, {(XLEN-1){1'b0}}};
        end
        in_xneg  = in_xsgn & in_xe[XLEN-1];
        in_yneg  = in_ysgn & in_ye[XLEN-1];
        in_xmag  = in_xneg ? -in_xe : in_xe;
        in_ymag  = in_yneg ? -in_ye : in_ye;
        div_zero = ~in_mul & (in_ye == '0);
        div_ovf  = ~in_mul & in_xsgn & (in_xe == in_min) & (in_ye == '1);
        in_exc   = div_zero | div_ovf;
        if (div_zero) begin
            exc_res = in_sub[1] ? (in_w ? in_x32s : X_i) : '1;
        end else begin
            exc_res = in_sub[1] ? '0 : in_xe;
        end
    end

    assign accept  = (state_q == S_IDLE) & req_valid_i & ~flush_i;
    assign timeout = (state_q == S_WAIT) & ~core_done_i & ~flush_i
                   & (cnt_q == CW'(TIMEOUT_CYC - 1));

`ifdef MD_RESULT_CACHE_EN
    logic              cache_vld, cache_w, cache_sgn;
    logic [XLEN-1:0]   cache_x, cache_y, x_q, y_q;
    logic [2*XLEN-1:0] cache_dat;

    assign cache_hit = cache_vld & ~in_mul & ~in_exc & (X_i == cache_x) & (Y_i == cache_y)
                     & (in_w == cache_w) & ((~in_sub[0]) == cache_sgn);
    assign cache_res = cache_dat;

    // Raw operands form the key so a hit needs no re-derivation of magnitudes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cache_vld <= 1'b0;
            cache_w   <= 1'b0;
            cache_sgn <= 1'b0;
            cache_x   <= '0;
            cache_y   <= '0;
            cache_dat <= '0;
            x_q       <= '0;
            y_q       <= '0;
        end else begin
            if (accept) begin
                x_q <= X_i;
                y_q <= Y_i;
            end
            if (flush_i || timeout) begin
                cache_vld <= 1'b0;
            end else if (state_q == S_ISSUE && !op_q[2]) begin
                cache_vld <= 1'b0;
            end else if (state_q == S_WAIT && core_done_i && !op_q[2]) begin
                cache_vld <= 1'b1;
                cache_x   <= x_q;
                cache_y   <= y_q;
                cache_w   <= op_q[3];
                cache_sgn <= ~op_q[0];
                cache_dat <= core_res_i;
            end
        end
    end
`else
    assign cache_hit = 1'b0;
    assign cache_res = '0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        req_ready_o  = 1'b0;
        core_start_o = 1'b0;
        core_mul_o   = 1'b0;
        core_abort_o = 1'b0;
        res_valid_o  = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready_o = ~flush_i;
                if (accept) begin
                    if (in_exc)         state_d = S_RESP;
                    else if (cache_hit) state_d = S_FIX;
                    else                state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                core_start_o = 1'b1;
                core_mul_o   = op_q[2];
                core_abort_o = flush_i;
                state_d      = flush_i ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (flush_i) begin
                    core_abort_o = 1'b1;
                    state_d      = S_IDLE;
                end else if (core_done_i) begin
                    state_d = S_FIX;
                end else if (timeout) begin
                    core_abort_o = 1'b1;
                    state_d      = S_RESP;
                end
            end
            S_FIX: begin
                state_d = flush_i ? S_IDLE : S_RESP;
            end
            S_RESP: begin
                res_valid_o = 1'b1;
                if (flush_i || res_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (state_q == S_WAIT) begin
            cnt_q <= cnt_q + CW'(1);
        end else begin
            cnt_q <= '0;
        end
    end

    // Sign fixup and result select; neg flags already encode signedness.
    always_comb begin
        quot = res_full_q[XLEN-1:0];
        rem  = res_full_q[2*XLEN-1:XLEN];
        prod = (neg_x_q ^ neg_y_q) ? -res_full_q : res_full_q;
        if (op_q[2]) begin
            sel = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end else if (op_q[1]) begin
            sel = neg_x_q ? -rem : rem;
        end else begin
            sel = (neg_x_q ^ neg_y_q) ? -quot : quot;
        end
        fix_res = op_q[3] ? {{(XLEN-32){sel[31]}}, sel[31:0]} : sel;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q       <= '0;
            mag_x_q    <= '0;
            mag_y_q    <= '0;
            neg_x_q    <= 1'b0;
            neg_y_q    <= 1'b0;
            res_full_q <= '0;
            res_q      <= '0;
            exc_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= md_op_i;
                mag_x_q <= in_xmag;
                mag_y_q <= in_ymag;
                neg_x_q <= in_xneg;
                neg_y_q <= in_yneg;
                exc_q   <= in_exc;
                err_q   <= 1'b0;
                if (in_exc)    res_q      <= exc_res;
                if (cache_hit) res_full_q <= cache_res;
            end
            if (state_q == S_WAIT && !flush_i) begin
                if (core_done_i) begin
                    res_full_q <= core_res_i;
                end else if (timeout) begin
                    res_q <= '0;
                    err_q <= 1'b1;
                end
            end
            if (state_q == S_FIX && !flush_i) res_q <= fix_res;
        end
    end

    assign core_X_o = mag_x_q;
    assign core_Y_o = mag_y_q;
    assign res_o    = res_q;
    assign exc_o    = exc_q;
    assign err_o    = err_q;

endmodule
